// File: rtl/jtag_tap_target.sv
// Target-side JTAG TAP for an ARM JTAG-DP: oversampled tck, 16-state TAP controller,
// IDCODE/DPACC/APACC/ABORT/BYPASS data registers and a req/resp access handshake.
module jtag_tap_target #(
    parameter logic [31:0] IDCODE = 32'h4BA00477,
    parameter int unsigned IRLEN  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tck,
    input  logic        tms,
    input  logic        tdi,
    output logic        tdo,
    output logic        req,
    output logic        apndp,
    output logic        rnw,
    output logic [1:0]  addr32,
    output logic [31:0] wdata,
    output logic        abort,
    input  logic        resp,
    input  logic [31:0] rdata,
    input  logic [2:0]  ack_in,
    output logic [3:0]  tap_state
);

    localparam logic [IRLEN-1:0] IrIdcode = IRLEN'(4'hE);
    localparam logic [IRLEN-1:0] IrDpacc  = IRLEN'(4'hA);
    localparam logic [IRLEN-1:0] IrApacc  = IRLEN'(4'hB);
    localparam logic [IRLEN-1:0] IrAbort  = IRLEN'(4'h8);
    localparam logic [2:0]       AckOk    = 3'b010;
    localparam logic [2:0]       AckWait  = 3'b001;

    typedef enum logic [3:0] {
        StTlr, StRti, StSelDr, StCapDr, StShDr, StEx1Dr, StPauDr, StEx2Dr,
        StUpdDr, StSelIr, StCapIr, StShIr, StEx1Ir, StPauIr, StEx2Ir, StUpdIr
    } tap_state_e;

    tap_state_e state_q, state_d;

    logic tck_meta, tck_sync, tck_prev;
    logic tms_meta, tms_sync;
    logic tdi_meta, tdi_sync;
    logic tck_rise, tck_fall;

    logic [IRLEN-1:0] ir_q, ir_sr;
    logic [34:0]      dr_sr;
    logic             pending_q;
    logic [31:0]      last_rdata_q;
    logic [2:0]       last_ack_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tck_meta <= 1'b0;
            tck_sync <= 1'b0;
            tck_prev <= 1'b0;
            tms_meta <= 1'b0;
            tms_sync <= 1'b0;
            tdi_meta <= 1'b0;
            tdi_sync <= 1'b0;
            state_q  <= StTlr;
        end else begin
            tck_meta <= tck;
            tck_sync <= tck_meta;
            tck_prev <= tck_sync;
            tms_meta <= tms;
            tms_sync <= tms_meta;
            tdi_meta <= tdi;
            tdi_sync <= tdi_meta;
            state_q  <= state_d;
        end
    end

    assign tck_rise  = tck_sync & ~tck_prev;
    assign tck_fall  = ~tck_sync & tck_prev;
    assign tap_state = state_q;

    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            unique case (state_q)
                StTlr:   state_d = tms_sync ? StTlr   : StRti;
                StRti:   state_d = tms_sync ? StSelDr : StRti;
                StSelDr: state_d = tms_sync ? StSelIr : StCapDr;
                StCapDr: state_d = tms_sync ? StEx1Dr : StShDr;
                StShDr:  state_d = tms_sync ? StEx1Dr : StShDr;
                StEx1Dr: state_d = tms_sync ? StUpdDr : StPauDr;
                StPauDr: state_d = tms_sync ? StEx2Dr : StPauDr;
                StEx2Dr: state_d = tms_sync ? StUpdDr : StShDr;
                StUpdDr: state_d = tms_sync ? StSelDr : StRti;
                StSelIr: state_d = tms_sync ? StTlr   : StCapIr;
                StCapIr: state_d = tms_sync ? StEx1Ir : StShIr;
                StShIr:  state_d = tms_sync ? StEx1Ir : StShIr;
                StEx1Ir: state_d = tms_sync ? StUpdIr : StPauIr;
                StPauIr: state_d = tms_sync ? StEx2Ir : StPauIr;
                StEx2Ir: state_d = tms_sync ? StUpdIr : StShIr;
                StUpdIr: state_d = tms_sync ? StSelDr : StRti;
                default: state_d = StTlr;
            endcase
        end
    end

    logic        dr_is_idcode, dr_is_acc, dr_is_abort;
    logic [2:0]  cap_ack;
    logic [34:0] dr_capture;
    logic        upd_dr, resp_hit, pending_eff, start_acc, abort_hit;

    assign dr_is_idcode = (ir_q == IrIdcode);
    assign dr_is_acc    = (ir_q == IrDpacc) || (ir_q == IrApacc);
    assign dr_is_abort  = (ir_q == IrAbort);
    assign cap_ack      = pending_q ? AckWait : last_ack_q;

    always_comb begin
        dr_capture = '0;
        if (dr_is_idcode) begin
            dr_capture = {3'b000, IDCODE};
        end else if (dr_is_acc) begin
            dr_capture = {last_rdata_q, cap_ack};
        end
    end

    // A response landing with the update retires the old access before the new one starts.
    assign upd_dr      = tck_rise && (state_q == StUpdDr);
    assign resp_hit    = resp && pending_q;
    assign pending_eff = pending_q && !resp;
    assign start_acc   = upd_dr && dr_is_acc && !pending_eff;
    assign abort_hit   = upd_dr && dr_is_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q  <= IrIdcode;
            ir_sr <= '0;
            dr_sr <= '0;
            tdo   <= 1'b0;
        end else begin
            if (tck_rise) begin
                if (state_q == StCapIr) begin
                    ir_sr <= IRLEN'(1);
                end else if (state_q == StShIr) begin
                    ir_sr <= {tdi_sync, ir_sr[IRLEN-1:1]};
                end

                if (state_q == StUpdIr) begin
                    ir_q <= ir_sr;
                end else if (state_d == StTlr) begin
                    ir_q <= IrIdcode;
                end

                if (state_q == StCapDr) begin
                    dr_sr <= dr_capture;
                end else if (state_q == StShDr) begin
                    if (dr_is_idcode) begin
                        dr_sr <= {3'b000, tdi_sync, dr_sr[31:1]};
                    end else if (dr_is_acc || dr_is_abort) begin
                        dr_sr <= {tdi_sync, dr_sr[34:1]};
                    end else begin
                        dr_sr <= {34'd0, tdi_sync};
                    end
                end
            end

            if (tck_fall) begin
                if (state_q == StShIr) begin
                    tdo <= ir_sr[0];
                end else if (state_q == StShDr) begin
                    tdo <= dr_sr[0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req          <= 1'b0;
            abort        <= 1'b0;
            apndp        <= 1'b0;
            rnw          <= 1'b0;
            addr32       <= 2'b00;
            wdata        <= 32'd0;
            pending_q    <= 1'b0;
            last_rdata_q <= 32'd0;
            last_ack_q   <= AckOk;
        end else begin
            req       <= start_acc;
            abort     <= abort_hit;
            pending_q <= (pending_eff && !abort_hit) || start_acc;

            if (resp_hit) begin
                last_rdata_q <= rdata;
                last_ack_q   <= ack_in;
            end
            // An abort that cancels an outstanding access leaves WAIT as the reported ack.
            if (abort_hit && pending_eff) begin
                last_ack_q <= AckWait;
            end
            if (start_acc) begin
                apndp  <= (ir_q == IrApacc);
                rnw    <= dr_sr[0];
                addr32 <= dr_sr[2:1];
                wdata  <= dr_sr[34:3];
            end
        end
    end

endmodule

// File: doc/jtag_tap_target.md
Name: jtag_tap_target

Overview:
- Target-side JTAG TAP responder for an ARM JTAG-DP. It is the far end of the host-side JTAG driver, used as a simulation and FPGA loopback target and as a DP front end.
- Oversamples incoming tck on the system clock and runs the standard 16-state TAP controller.
- Implements a 4-bit IR with IDCODE, DPACC, APACC, ABORT and BYPASS data registers.
- Presents completed DP/AP accesses upward on a req/resp handshake and returns read data plus ack on the next scan.

Parameters:
- IDCODE, 32'h4BA00477, value captured into the IDCODE DR
- IRLEN, 4, instruction register length in bits (fixed at 4 for ARM DP)

Ports:
- clk  input  1  system clock; must be at least 4x tck frequency
- rst  input  1  asynchronous, active-high reset
- tck  input  1  JTAG test clock from host (asynchronous)
- tms  input  1  test mode select from host
- tdi  input  1  test data in from host
- tdo  output 1  test data out to host
- req  output 1  one-clk pulse: DPACC/APACC access completed at Update-DR
- apndp  output 1  1=AP access, 0=DP access; valid with req
- rnw  output 1  1=read, 0=write; valid with req
- addr32  output 2  address bits 3:2; valid with req
- wdata  output 32  write data; valid with req
- abort  output 1  one-clk pulse on Update-DR with IR=ABORT
- resp  input  1  one-clk pulse: upper layer finished the access
- rdata  input 32  read data, sampled with resp
- ack_in  input 3  ack code, sampled with resp (3'b010 OK/FAULT, 3'b001 WAIT)
- tap_state  output 4  current TAP state, for debug

Behaviour:
- Async reset values:
  - TAP state Test-Logic-Reset; IR=4'hE (IDCODE); tdo=0; req=0; abort=0
  - apndp, rnw, addr32, wdata = 0; pending=0; last_rdata=0; last_ack=3'b010
- Edge detect:
  - tck, tms and tdi pass through 2-flop synchronisers.
  - tck_rise = sync_tck & ~prev_tck; tck_fall = ~sync_tck & prev_tck.
  - Edge-to-action latency is 3 clk.
- TAP FSM:
  - Advances only on tck_rise, using the synchronised tms.
  - Uses the standard IEEE 1149.1 16 states with encoding 0..15 in IEEE order: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauIR, Ex2IR, UpdIR.
  - Five consecutive tms=1 rising edges reach TLR from any state.
  - Entering TLR sets IR=4'hE.
- IR path:
  - On tck_rise in CapIR, shift register loads 4'b0001.
  - On tck_rise in ShIR, shift right with tdi into bit 3.
  - On tck_rise in UpdIR, IR <= shift register.
- DR selection:
  - IR=4'hE: IDCODE (32 bits)
  - IR=4'hA: DPACC (35 bits)
  - IR=4'hB: APACC (35 bits)
  - IR=4'h8: ABORT (35 bits)
  - All other IR values: BYPASS (1 bit, captures 0)
- DR capture (tck_rise in CapDR):
  - IDCODE DR loads IDCODE.
  - DPACC/APACC DR loads {last_rdata, ack}, where ack = pending ? 3'b001 : last_ack.
  - ABORT DR loads 0.
- DR shift (tck_rise in ShDR):
  - Shift right, LSB first; tdi enters the top bit of the selected length (bit 34, 31 or 0).
  - After 35 shifts: bit0=rnw, bits2:1=addr32, bits34:3=wdata.
- tdo:
  - Updated on tck_fall only, to the LSB of the active IR/DR shift register while in ShIR/ShDR.
  - Otherwise holds its last value.
- Update-DR (tck_rise in UpdDR):
  - DPACC/APACC with pending=0:
    - req=1 for one clk; latch apndp/rnw/addr32/wdata; pending <= 1.
  - DPACC/APACC with pending=1:
    - Access is discarded; no req (WAIT was already reported in capture).
  - ABORT:
    - abort pulse for one clk.
    - If pending, pending <= 0 and last_ack <= 3'b001.
- Response:
  - resp while pending: last_rdata <= rdata; last_ack <= ack_in; pending <= 0.
  - resp while not pending: ignored.
  - resp in the same clk as an Update-DR that raises req: the old transaction completes first, then the new one sets pending.
- Reset mid-scan: all state returns to reset values immediately; a partial shift is lost.
- A transaction whose shift is abandoned (no UpdDR visit) raises no req.

Test Plan:
- Reset, then 5x tms=1, tms=0, then SelDR/CapDR/ShDR and 32 shifts -> tdo stream equals 32'h4BA00477 LSB first; tap_state=4 during the shift.
- Scan IR=4'hA, then DR in={wdata=32'h12345678, addr32=2'b01, rnw=0} -> one req pulse with apndp=0, addr32=1, wdata=32'h12345678; the scanned-out IR capture is 4'b0001.
- After the write, resp with ack_in=3'b010, then a DR scan with rnw=1 -> captured ack is 3'b010; resp with rdata=32'hCAFEF00D; the next scan shifts out ack 010 then data 32'hCAFEF00D.
- With req outstanding (no resp), scan DPACC again -> captured ack 3'b001 and no second req pulse.
- IR=4'hF, then shift 8 bits -> tdo equals tdi delayed by one tck with a leading 0.
- Assert rst halfway through a 35-bit shift -> tap_state=0, IR=4'hE, req=0 and pending cleared within 1 clk.
